// File: rtl/lab2_proc_iter_muldiv_unit.sv
// ----------------------------------------------------------------------------
// lab2_proc_iter_muldiv_unit
//
// Iterative RV32M execute unit that sits beside the ALU in the X stage.
// It handles all eight M-extension ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU,
// REM and REMU, at width p_nbits. A request is issued from D. The result is
// muxed into the X result. Latency varies, so both sides use a val/rdy
// handshake and the pipeline control stalls on those handshakes.
//
// Multiply uses shift-add on operand magnitudes into a 2*N accumulator. The
// product is negated at the end when the operand signs differ. Divide is
// restoring, producing one quotient bit per cycle. Divide-by-zero and signed
// overflow skip the datapath and complete in a single cycle.
//
// Parameters
//   p_nbits       operand/result width (>= 4)
//   p_early_exit  1: a multiply ends once the remaining multiplier bits are 0
//
// Ports
//   clk       in   1        clock
//   reset     in   1        asynchronous, active-low reset
//   req_val   in   1        request valid
//   req_rdy   out  1        unit can accept a request (IDLE, out of reset)
//   req_op    in   3        0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   req_a     in   p_nbits  rs1 operand
//   req_b     in   p_nbits  rs2 operand
//   resp_val  out  1        result valid (DONE)
//   resp_rdy  in   1        consumer accepts result
//   resp_msg  out  p_nbits  result, held stable while waiting in DONE
//   busy      out  1        state != IDLE
// ----------------------------------------------------------------------------
module lab2_proc_iter_muldiv_unit #(
    parameter int p_nbits      = 32,
    parameter bit p_early_exit = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_op,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_msg,
    output logic               busy
);

    localparam int N  = p_nbits;
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    state_e state_q, state_d;

    // ------------------------------------------------------------------
    // Request decode (valid only while IDLE)
    // ------------------------------------------------------------------
    op_e          req_op_e;
    logic         a_signed, b_signed;
    logic         req_sa, req_sb;
    logic [N-1:0] req_a_mag, req_b_mag;
    logic         req_b_zero, req_ovf, req_special;
    logic [N-1:0] special_result;
    logic         accept;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        req_op_e    = op_e'(req_op);
        a_signed    = (req_op_e == OP_MULH) || (req_op_e == OP_MULHSU) ||
                      (req_op_e == OP_DIV)  || (req_op_e == OP_REM);
        b_signed    = (req_op_e == OP_MULH) || (req_op_e == OP_DIV) ||
                      (req_op_e == OP_REM);
        req_sa      = a_signed && req_a[N-1];
        req_sb      = b_signed && req_b[N-1];
        req_a_mag   = req_sa ? (~req_a + 1'b1) : req_a;
        req_b_mag   = req_sb ? (~req_b + 1'b1) : req_b;
        req_b_zero  = (req_b == '0);
        req_ovf     = ((req_op_e == OP_DIV) || (req_op_e == OP_REM)) &&
                      (req_a == MOST_NEG) && (req_b == '1);
        req_special = req_op[2] && (req_b_zero || req_ovf);

        // Bit 1 of a divide opcode selects the remainder.
        if (req_b_zero) begin
            special_result = req_op[1] ? req_a : '1;
        end else begin
            special_result = req_op[1] ? '0 : req_a;
        end
    end

    // ------------------------------------------------------------------
    // Iteration state
    // ------------------------------------------------------------------
    op_e           op_q;
    logic          sa_q, sb_q;
    logic [CW-1:0] cnt_q;
    logic [2*N-1:0] acc_q;     // product accumulator
    logic [2*N-1:0] mcand_q;   // |a|, shifted left each step
    logic [N-1:0]  mplier_q;   // |b|, shifted right each step
    logic [N-1:0]  rem_q;      // partial remainder
    logic [N-1:0]  quo_q;      // dividend shifting out, quotient shifting in
    logic [N-1:0]  dsr_q;      // divisor magnitude
    logic [N-1:0]  result_q;

    // ------------------------------------------------------------------
    // One datapath step plus final sign fix-up
    // ------------------------------------------------------------------
    logic [2*N-1:0] mul_acc_nxt, mcand_nxt, prod;
    logic [N-1:0]   mplier_nxt;
    logic           mul_last;
    logic [N:0]     rem_shift;
    logic           rem_ge;
    logic [N-1:0]   rem_nxt, quo_nxt, quo_fin, rem_fin;
    logic           div_last, step_last;
    logic [N-1:0]   calc_result;

    always_comb begin
        mul_acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mcand_nxt   = mcand_q << 1;
        mplier_nxt  = mplier_q >> 1;
        // Early exit stops once no multiplier bits remain. Even b == 0
        // still spends one CALC cycle.
        mul_last    = (cnt_q == CW'(1)) || (p_early_exit && (mplier_nxt == '0));
        prod        = (sa_q ^ sb_q) ? (~mul_acc_nxt + 1'b1) : mul_acc_nxt;

        rem_shift   = {rem_q, quo_q[N-1]};
        rem_ge      = (rem_shift >= {1'b0, dsr_q});
        rem_nxt     = rem_ge ? N'(rem_shift - {1'b0, dsr_q}) : rem_shift[N-1:0];
        quo_nxt     = {quo_q[N-2:0], rem_ge};
        div_last    = (cnt_q == CW'(1));
        quo_fin     = (sa_q ^ sb_q) ? (~quo_nxt + 1'b1) : quo_nxt;
        rem_fin     = sa_q ? (~rem_nxt + 1'b1) : rem_nxt;

        step_last   = op_q[2] ? div_last : mul_last;

        calc_result = '0;
        case (op_q)
            OP_MUL:                      calc_result = prod[N-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod[2*N-1:N];
            OP_DIV, OP_DIVU:             calc_result = quo_fin;
            default:                     calc_result = rem_fin;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples pre-edge values and ordering between blocks is moot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        busy     = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // Held low during reset, so nothing is accepted while the
                // unit is still coming out of reset.
                req_rdy = reset;
                if (req_val && req_rdy) begin
                    state_d = req_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (step_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept   = req_val && req_rdy;
    assign resp_msg = result_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: these are plain registers, not a memory array. Resetting them
    // keeps resp_msg at 0 out of reset and drops any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= req_op_e;
            sa_q     <= req_sa;
            sb_q     <= req_sb;
            cnt_q    <= CW'(N);
            acc_q    <= '0;
            mcand_q  <= {{N{1'b0}}, req_a_mag};
            mplier_q <= req_b_mag;
            rem_q    <= '0;
            quo_q    <= req_a_mag;
            dsr_q    <= req_b_mag;
            if (req_special) begin
                result_q <= special_result;
            end
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - 1'b1;
            if (op_q[2]) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
            end else begin
                acc_q    <= mul_acc_nxt;
                mcand_q  <= mcand_nxt;
                mplier_q <= mplier_nxt;
            end
            if (step_last) begin
                result_q <= calc_result;
            end
        end
    end

endmodule

// File: tb/tb_lab2_proc_iter_muldiv_unit.sv
`timescale 1ns/1ps
// Self-checking bench for lab2_proc_iter_muldiv_unit (p_nbits=32, early exit on).
// A vector table drives single operations: result plus exact latency. Each
// expected result is queued at the accepting edge and popped when resp_val
// rises. Hand-written sequences then cover backpressure in DONE and reset
// arriving mid-divide.
module tb_lab2_proc_iter_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_msg;
    logic        busy;

    lab2_proc_iter_muldiv_unit #(
        .p_nbits      (32),
        .p_early_exit (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present a request at a negedge. Bounded wait for req_rdy. Queue the
    // expected result at the accepting posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int w;
        w = 0;
        @(negedge clk);
        req_val = 1'b1;
        req_op  = op;
        req_a   = a;
        req_b   = b;
        while (!req_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept_rdy", 32'(req_rdy), 32'd1);
        @(posedge clk);
        sb_q.push_back(exp);
        #1;
        req_val = 1'b0;
    endtask

    // Count cycles from the accepting edge (that edge counts as cycle 1) to
    // the first edge after which resp_val is high. Optionally stall for hold
    // cycles, then handshake and confirm the unit is back in IDLE.
    task automatic collect(input string name, input int exp_lat, input int hold);
        int          cyc;
        logic [31:0] e;
        cyc = 1;
        @(negedge clk);
        while (!resp_val && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_resp_val"}, 32'(resp_val), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        check({name, "_msg"}, resp_msg, e);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({name, "_hold_msg"}, resp_msg, e);
            check({name, "_hold_req_rdy"}, 32'(req_rdy), 32'd0);
            check({name, "_hold_busy"}, 32'(busy), 32'd1);
            check({name, "_hold_resp_val"}, 32'(resp_val), 32'd1);
        end
        resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        resp_rdy = 1'b0;
        @(negedge clk);
        check({name, "_post_req_rdy"}, 32'(req_rdy), 32'd1);
        check({name, "_post_busy"}, 32'(busy), 32'd0);
        check({name, "_post_resp_val"}, 32'(resp_val), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int stale;
        //         op     a             b             exp           lat
        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd33};
        vecs[1]  = '{3'd0, 32'h0000_0005, 32'h0000_0001, 32'h0000_0005, 8'd2};
        vecs[2]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 8'd33};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33};
        vecs[4]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 8'd3};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 8'd33};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33};
        vecs[7]  = '{3'd5, 32'd100,       32'd7,         32'd14,        8'd33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1};
        vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5,         8'd1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 8'd1};
        vecs[12] = '{3'd0, 32'd3,         32'd0,         32'd0,         8'd2};
        vecs[13] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 8'd2};
        vecs[14] = '{3'd4, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 8'd1};
        vecs[15] = '{3'd6, 32'd20,        32'hFFFF_FFFA, 32'd2,         8'd33};
        vecs[16] = '{3'd4, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, 8'd33};
        vecs[17] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd33};
        vecs[18] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 8'd33};
        vecs[19] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 8'd33};

        reset    = 1'b0;
        req_val  = 1'b0;
        req_op   = 3'd0;
        req_a    = '0;
        req_b    = '0;
        resp_rdy = 1'b0;

        // Reset state while reset is held low.
        repeat (2) @(negedge clk);
        check("rst_resp_val", 32'(resp_val), 32'd0);
        check("rst_resp_msg", resp_msg, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        reset = 1'b1;

        // Table-driven single operations.
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            collect($sformatf("vec%0d", i), int'(vecs[i].lat), 0);
        end

        // Backpressure: DIVU 100/7 with resp_rdy held low for 5 cycles in DONE.
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        collect("backpressure", 33, 5);

        // Reset mid-CALC of a DIV. Nothing stale may appear afterwards.
        issue(3'd4, 32'd100, 32'd7, 32'd14);
        repeat (10) @(negedge clk);
        check("midcalc_busy", 32'(busy), 32'd1);
        check("midcalc_req_rdy", 32'(req_rdy), 32'd0);
        check("midcalc_resp_val", 32'(resp_val), 32'd0);
        reset = 1'b0;
        #1;
        check("async_rst_resp_val", 32'(resp_val), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b1;
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        collect("after_reset_mul", 4, 0);
        stale = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_val) stale++;
        end
        check("no_stale_resp", 32'(stale), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
